// File: rtl/conv_layer_scheduler.sv
// Sequencer sharing one 4-tap MAC across NUM_LAYERS dilated causal conv layers.
// Per sample: step each layer's cache, start the MAC, feed the result forward.
// Optional feature: define SCHED_RELU_EN to clamp negative inter-layer results to 0.
module conv_layer_scheduler #(
  parameter int unsigned W          = 16,
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned LW         = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic [NUM_LAYERS-1:0] cache_step,
  output logic [W-1:0]          cache_inp,
  output logic [LW-1:0]         layer_sel,
  output logic                  mac_start,
  input  logic                  mac_done,
  input  logic [W-1:0]          mac_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  busy,
  output logic [15:0]           sample_count
);

  typedef enum logic [2:0] {StIdle, StStep, StStart, StWait, StOut} state_e;

  localparam logic [LW-1:0] LastLayer = LW'(NUM_LAYERS - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [15:0]   sample_count_q, sample_count_d;
  logic          ready_q, ready_d;

  // Inter-layer activation; the final-layer result bypasses it.
  function automatic logic [W-1:0] act(input logic [W-1:0] x);
`ifdef SCHED_RELU_EN
    return x[W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // State and datapath registers; ready_q holds off acceptance for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      layer_q        <= '0;
      cur_q          <= '0;
      out_data_q     <= '0;
      sample_count_q <= '0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      layer_q        <= layer_d;
      cur_q          <= cur_d;
      out_data_q     <= out_data_d;
      sample_count_q <= sample_count_d;
      ready_q        <= ready_d;
    end
  end

  // Next-state and strobe decode; all outputs default to inactive/zero.
  always_comb begin
    state_d        = state_q;
    layer_d        = layer_q;
    cur_d          = cur_q;
    out_data_d     = out_data_q;
    sample_count_d = sample_count_q;
    ready_d        = 1'b1;
    in_ready       = 1'b0;
    cache_step     = '0;
    cache_inp      = '0;
    layer_sel      = '0;
    mac_start      = 1'b0;
    out_valid      = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = ready_q;
        if (in_valid && ready_q) begin
          cur_d   = in_data;
          layer_d = '0;
          state_d = StStep;
        end
      end
      StStep: begin
        cache_step[layer_q] = 1'b1;
        cache_inp           = cur_q;
        layer_sel           = layer_q;
        state_d             = StStart;
      end
      StStart: begin
        // Taps registered by the cache during StStep are valid now.
        mac_start = 1'b1;
        layer_sel = layer_q;
        state_d   = StWait;
      end
      StWait: begin
        layer_sel = layer_q;
        if (mac_done) begin
          if (layer_q != LastLayer) begin
            cur_d   = act(mac_result);
            layer_d = layer_q + 1'b1;
            state_d = StStep;
          end else begin
            out_data_d = mac_result;
            state_d    = StOut;
          end
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          sample_count_d = sample_count_q + 16'd1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign out_data     = out_data_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler with a cycle-stepped MAC model and
// an output scoreboard queue.
module tb_conv_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  cache_step;
  logic [15:0] cache_inp;
  logic [1:0]  layer_sel;
  logic        mac_start;
  logic        mac_done = 1'b0;
  logic [15:0] mac_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] sample_count;

  int          errors = 0;
  int          checks = 0;
  int          exp_count = 0;
  logic [15:0] exp_q[$];

  conv_layer_scheduler #(.W(16), .NUM_LAYERS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .cache_step   (cache_step),
    .cache_inp    (cache_inp),
    .layer_sel    (layer_sel),
    .mac_start    (mac_start),
    .mac_done     (mac_done),
    .mac_result   (mac_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tb_act(input logic [15:0] x);
`ifdef SCHED_RELU_EN
    return x[15] ? 16'd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cache_step", cache_step, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_layer_sel", layer_sel, 0);
    chk("rst_cache_inp", cache_inp, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sample_count", sample_count, 0);
  endtask

  // MAC model returns tap+1 (or res0 for layer 0 when ovr0), done ks[L] cycles after start.
  task automatic run_sample(input logic [15:0] d, input int k0, input int k1, input int k2,
                            input int k3, input bit ovr0, input logic [15:0] res0,
                            input int stall, input bit spur_start, input int abort_layer);
    int          ks[4];
    logic [15:0] cur;
    logic [15:0] res;
    logic [15:0] fin;
    logic [15:0] exp_out;
    ks = '{k0, k1, k2, k3};
    cur = d;
    fin = '0;
    for (int l = 0; l < 4; l++) begin
      res = (l == 0 && ovr0) ? res0 : cur + 16'd1;
      if (l < 3) cur = tb_act(res);
      else fin = res;
    end
    if (abort_layer < 0) exp_q.push_back(fin);

    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    cur = d;
    for (int l = 0; l < 4; l++) begin
      chk("step_onehot", cache_step, 32'd1 << l);
      chk("step_cache_inp", cache_inp, cur);
      chk("step_layer_sel", layer_sel, l);
      chk("step_busy_ready", {busy, in_ready, mac_start}, 3'b100);
      @(negedge clk);
      chk("start_strobes", {mac_start, cache_step}, 5'b10000);
      chk("start_layer_sel", layer_sel, l);
      mac_done   = spur_start;
      mac_result = 16'h7fff;
      res = (l == 0 && ovr0) ? res0 : cur + 16'd1;
      for (int j = 1; j <= ks[l]; j++) begin
        @(negedge clk);
        if (abort_layer == l) begin
          mac_done = 1'b0;
          rst = 1'b0;
          #1;
          check_reset_outputs();
          exp_count = 0;
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          @(negedge clk);
          return;
        end
        chk("wait_quiet", {mac_start, cache_step, out_valid}, 0);
        chk("wait_layer_sel", layer_sel, l);
        mac_done   = (j == ks[l]);
        mac_result = (j == ks[l]) ? res : 16'h7fff;
      end
      @(negedge clk);
      mac_done = 1'b0;
      if (l < 3) cur = tb_act(res);
    end

    exp_out = exp_q.pop_front();
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp_out);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 1; s < stall; s++) begin
        @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, exp_out);
        chk("stall_quiet", {cache_step, in_ready, mac_start}, 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    chk("post_idle", {busy, out_valid, in_ready}, 3'b001);
    chk("sample_count", sample_count, exp_count);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_reset", {in_ready, busy}, 2'b10);

    // Single sample, k=1: taps 100..103, result 104 in cycle 13
    run_sample(16'd100, 1, 1, 1, 1, 1'b0, 16'd0, 0, 1'b0, -1);

    // Variable MAC latency: out_valid at cycle 20
    run_sample(16'd7, 1, 5, 2, 3, 1'b0, 16'd0, 0, 1'b0, -1);

    // Backpressure for 10 cycles, negative input
    run_sample(16'hfffd, 2, 1, 1, 2, 1'b0, 16'd0, 10, 1'b0, -1);

    // Negative intermediate from layer 0
    run_sample(16'd20, 1, 2, 1, 1, 1'b1, 16'hffce, 0, 1'b0, -1);

    // Spurious done in IDLE, then in START of every layer
    mac_done   = 1'b1;
    mac_result = 16'h1234;
    @(negedge clk);
    mac_done = 1'b0;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_quiet", {cache_step, mac_start}, 0);
    run_sample(16'd500, 2, 3, 1, 2, 1'b0, 16'd0, 0, 1'b1, -1);

    // Reset asserted in layer-2 WAIT, then a fresh sample from layer 0
    run_sample(16'd40, 1, 1, 3, 1, 1'b0, 16'd0, 0, 1'b0, 2);
    run_sample(16'd9, 1, 1, 1, 1, 1'b0, 16'd0, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Sequencer that time-shares one 4-tap dot-product (MAC) unit across a stack of `NUM_LAYERS` dilated causal convolution layers. Each layer has its own activation cache, which has a step enable. Per input sample the block advances each layer's cache in order, starts the MAC on that layer's taps, and feeds the result forward as the next layer's input. It sits between the sample source and the output sink, and owns the cache step strobes, the layer select and the MAC start.

## Interface
- `W`, 16: signed sample/activation width.
- `NUM_LAYERS`, 4: number of layers (≥2); layer L uses dilation 2^L externally.
- `LW`, `$clog2(NUM_LAYERS)`: layer index width.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input sample offered.
- `in_ready` out 1: block can accept a sample.
- `in_data` in W: input sample, signed.
- `cache_step` out NUM_LAYERS: one-hot, 1-cycle pulse; cache L writes `cache_inp` and advances.
- `cache_inp` out W: value written into the stepped cache.
- `layer_sel` out LW: selects the cache taps and weights routed to the MAC.
- `mac_start` out 1: 1-cycle pulse; MAC samples its taps this cycle.
- `mac_done` in 1: MAC result valid, 1-cycle pulse.
- `mac_result` in W: MAC output, signed.
- `out_valid` out 1: final-layer result available.
- `out_ready` in 1: sink accepts the result.
- `out_data` out W: final-layer result.
- `busy` out 1: high in every state except IDLE.
- `sample_count` out 16: completed output handshakes, wraps at 2^16.

## Operation
- FSM states: IDLE, STEP, START, WAIT, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_data` into `cur`, set `layer`=0, go to STEP.
- STEP:
  - `cache_step[layer]`=1, `cache_inp`=`cur`, `layer_sel`=`layer`.
  - Go to START.
  - The cache taps are registered, so they are valid on the next cycle.
- START:
  - `mac_start`=1, `layer_sel` held.
  - Go to WAIT.
- WAIT:
  - Hold `layer_sel` until `mac_done`.
  - If `layer`<NUM_LAYERS-1: `cur`←act(`mac_result`), `layer`++, go to STEP.
  - Otherwise: `out_data`←`mac_result`, go to OUT.
- OUT:
  - `out_valid`=1 and `out_data` stable until `out_ready`.
  - On the handshake, `sample_count`++ and go to IDLE.
- `mac_done` is ignored in IDLE, STEP, START and OUT. A `mac_done` in the START cycle is therefore dropped, and the MAC contract requires done ≥1 cycle after start.
- `cache_step` and `mac_start` are never asserted outside STEP and START respectively. No cache advances while OUT is stalled.
- `cache_inp` and `layer_sel` are 0 when not in use.
- `mac_result` is consumed unmodified at W bits; no width growth in this block.
- `layer` never exceeds NUM_LAYERS-1; there is no wrap inside a sample.

## Timing
- Reset values:
  - State IDLE; `layer`, `cur`, `out_data`, `sample_count` = 0.
  - All strobes 0; `out_valid`=0, `busy`=0.
  - `in_ready`=1 one cycle after `rst` deasserts.
- Reset asserted mid-sample: abort immediately with no further strobes. External cache contents are not this block's concern.
- If the MAC returns done k cycles after start (k≥1), each layer takes k+2 cycles.
- Accept to `out_valid` = NUM_LAYERS·(k+2) cycles; `out_valid` is high in cycle NUM_LAYERS·(k+2)+1 after the accept cycle.
- Example: NUM_LAYERS=4, k=1 → accept in cycle 0, `out_valid` in cycle 13.
- Throughput: one sample per NUM_LAYERS·(k+2)+2 cycles with `out_ready` held high. `in_ready` is low from the accept edge until return to IDLE.

## Configuration
- `SCHED_RELU_EN` defined:
  - Inter-layer act(x) = (x<0) ? 0 : x, applied to results fed into layers 1..NUM_LAYERS-1.
  - The final-layer result is not clamped.
- Undefined: act(x)=x; results pass straight through.

## Test plan
- Reset, then single sample:
  - Stimulus: `in_data`=100, MAC model k=1 returning `cache_inp`+1.
  - Required: `cache_step` pulses 0001, 0010, 0100, 1000 with `cache_inp` 100, 101, 102, 103.
  - Required: `out_data`=104, `out_valid` in cycle 13, `sample_count`=1.
- Variable MAC latency:
  - Stimulus: k=1,5,2,3 per layer.
  - Required: `layer_sel` held through each WAIT; no extra `mac_start`; `out_valid` at cycle 20.
- Backpressure:
  - Stimulus: `out_ready`=0 for 10 cycles.
  - Required: `out_data` stable, `in_ready`=0, no `cache_step`; IDLE one cycle after the handshake.
- Negative intermediate:
  - Stimulus: MAC returns −50 for layer 0.
  - Required: layer 1 `cache_inp`=0 with `SCHED_RELU_EN`, −50 without.
- Spurious done:
  - Stimulus: `mac_done` pulsed in IDLE and in START.
  - Required: ignored; sequencing unchanged.
- Reset mid-sample:
  - Stimulus: assert `rst` low during layer-2 WAIT.
  - Required: all outputs take reset values asynchronously; the next sample starts at layer 0.
